mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency backing memory between the pipelined CPU's
//  fetch port (pc/inst/instReady) and data port (dataAddress/memRead/memWrite/memMode).
//  Sits between PipeCPU and the unified memory model.
//  - Grants one transaction at a time; data accesses have priority, with a starvation guard for fetch.
//  - Returns completion pulses (instReady, dataReady); the CPU stalls until it sees them.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  MMD_W        3  memMode width (byte/half/word + signed/unsigned encoding, passed through unchanged)
//  STARVE_MAX   4  consecutive data grants while fetch pending before fetch is forced next (>=1)
//  TIMEOUT    255  cycles in BUSY without memAck before abort (8-bit counter; 0 disables)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  pc           in   AW     fetch address; request is implicit whenever reset is low
//  inst         out  DW     fetched word; valid while instReady=1
//  instReady    out  1      one-cycle fetch-complete pulse
//  dataAddress  in   AW     data address
//  writeMemData in   DW     store data
//  memRead      in   1      load request, level; held until dataReady
//  memWrite     in   1      store request, level; held until dataReady
//  memMode      in   MMD_W  access size/sign
//  readMemData  out  DW     load result; valid while dataReady=1
//  dataReady    out  1      one-cycle data-complete pulse (loads and stores)
//  mReq         out  1      backing-memory request, held until mAck
//  mWe          out  1      1 = write
//  mAddr        out  AW     latched address
//  mWData       out  DW     latched store data
//  mMode        out  MMD_W  latched mode; fetch always uses the word mode
//  mAck         in   1      backing-memory completion, one cycle
//  mRData       in   DW     read data, valid with mAck
//  busErr       out  1      sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: mReq, mWe, instReady, dataReady, busErr, inst,
//   readMemData, mAddr, mWData, mMode. Counters are 0. Reset asserted mid-transaction drops mReq
//   immediately; the in-flight access is abandoned and a late mAck is ignored.
//  FSM states: IDLE, BUSY_I, BUSY_D, DONE.
//   IDLE -> BUSY_D  if memRead|memWrite, unless starveCnt==STARVE_MAX.
//   IDLE -> BUSY_I  otherwise (fetch is always pending).
//   On grant: register mAddr/mWData/mMode/mWe and set mReq=1. mReq is first high the cycle after grant.
//   memRead and memWrite both high: treated as a write.
//   BUSY_x, mAck=1 -> DONE. Register mRData into inst (BUSY_I) or readMemData (BUSY_D).
//    Drop mReq in the same edge.
//   DONE -> IDLE. The ready pulse is high during DONE, so minimum latency is
//    request seen in IDLE at cycle n, mAck at n+1, ready at n+2.
//  Stale fetch: if pc != latched mAddr in the mAck cycle of BUSY_I, instReady stays 0.
//   Go to DONE silently; pc is re-fetched from IDLE (covers branch flush).
//  Data request withdrawn mid-BUSY_D: the access still completes and dataReady still pulses.
//  starveCnt: +1 on each BUSY_D grant, saturating at STARVE_MAX; cleared on each BUSY_I grant.
//  Timeout: waitCnt counts BUSY cycles. At TIMEOUT: set busErr, drop mReq, go to DONE with no ready
//   pulse. The requester retries.
//  mAck outside BUSY_x is ignored.
//  No combinational path from any input to mReq/mAddr/mWe.
// CONFIGURATION
//  INST_BUF_EN defined: one-entry fetch buffer {valid, tag[AW], word[DW]}, filled on each
//   non-stale BUSY_I completion.
//   - In IDLE with no data request and pc==tag&&valid: go straight to DONE with inst=word and no
//     memory access. Latency is 1 cycle. Does not reset starveCnt.
//   - Any data write with mAddr[AW-1:2]==tag[AW-1:2] clears valid in its mAck cycle.
//   - Reset clears valid.
//  INST_BUF_EN undefined: no buffer; every fetch goes to memory. Behaviour otherwise identical.
// TESTING
//  Fetch only, mAck 1 cycle after mReq, pc=0x0, mRData=0x2402000A -> instReady pulse at cycle 2,
//   inst=0x2402000A, mWe=0.
//  memRead and fetch both pending in IDLE, dataAddress=0x100 -> data granted first:
//   mAddr=0x100, dataReady, then fetch granted.
//  memWrite held 6 back-to-back ops, STARVE_MAX=4 -> grants D,D,D,D,I,D,D with starveCnt back to 0
//   after I.
//  pc changes 0x8->0x40 during BUSY_I -> no instReady for 0x8; next grant is fetch of 0x40.
//  mAck never arrives, TIMEOUT=8 -> mReq drops after 8 BUSY cycles, busErr=1 sticky,
//   no ready pulse; reset mid-BUSY -> mReq=0 asynchronously.
//  INST_BUF_EN: fetch 0x10 twice -> second instReady 1 cycle after IDLE with no mReq;
//   store to 0x12 then fetch 0x10 -> mReq issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported, variable-latency backing memory
//               between the CPU fetch port and data port. One transaction is
//               in flight at a time. Data accesses win arbitration, but after
//               STARVE_MAX consecutive data grants with fetch pending the
//               next grant is forced to fetch. Completion is reported with
//               one-cycle instReady / dataReady pulses.
//
// Optional    : `define INST_BUF_EN adds a one-entry fetch buffer
//               {valid, tag, word}. A repeat fetch of the buffered pc
//               completes in one cycle without a memory access. A store
//               to the same word invalidates the buffer.
//
// Ports       : clk, reset          - clock, async active-high reset
//               pc / inst / instReady
//                                   - fetch port (fetch always pending)
//               dataAddress, writeMemData, memRead, memWrite, memMode,
//               readMemData, dataReady
//                                   - data port (level requests)
//               mReq, mWe, mAddr, mWData, mMode, mAck, mRData
//                                   - backing-memory handshake
//               busErr              - sticky timeout flag
//
// Parameters  : AW, DW, MMD_W       - address / data / mode widths
//               STARVE_MAX          - data grants before fetch is forced
//               TIMEOUT             - BUSY cycles before abort (0 = off)
//               WORD_MODE           - memMode encoding used for fetches
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter int                MMD_W      = 3,
    parameter int                STARVE_MAX = 4,
    parameter int                TIMEOUT    = 255,
    parameter logic [MMD_W-1:0]  WORD_MODE  = MMD_W'(2)
) (
    input  logic             clk,
    input  logic             reset,
    // fetch port
    input  logic [AW-1:0]    pc,
    output logic [DW-1:0]    inst,
    output logic             instReady,
    // data port
    input  logic [AW-1:0]    dataAddress,
    input  logic [DW-1:0]    writeMemData,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic [MMD_W-1:0] memMode,
    output logic [DW-1:0]    readMemData,
    output logic             dataReady,
    // backing memory
    output logic             mReq,
    output logic             mWe,
    output logic [AW-1:0]    mAddr,
    output logic [DW-1:0]    mWData,
    output logic [MMD_W-1:0] mMode,
    input  logic             mAck,
    input  logic [DW-1:0]    mRData,
    // status
    output logic             busErr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0]  c_STARVE_MAX = c_SW'(STARVE_MAX);
    localparam bit               c_TMO_EN     = (TIMEOUT != 0);
    // waitCnt starts at 0 on the first BUSY cycle, so the abort fires on the
    // TIMEOUT-th BUSY cycle when the count reads TIMEOUT-1.
    localparam logic [7:0]       c_TMO_LAST   = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic              r_mReq;
    logic              r_mWe;
    logic [AW-1:0]     r_mAddr;
    logic [DW-1:0]     r_mWData;
    logic [MMD_W-1:0]  r_mMode;
    logic [DW-1:0]     r_inst;
    logic              r_instReady;
    logic [DW-1:0]     r_readMemData;
    logic              r_dataReady;
    logic              r_busErr;
    logic [c_SW-1:0]   r_starve;
    logic [7:0]        r_wait;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_data_req;
    logic              w_starved;
    logic              w_timeout;
    logic              w_pc_match;
    logic              w_buf_hit;
    logic [DW-1:0]     w_buf_word;

    assign w_data_req = memRead | memWrite;
    assign w_starved  = (r_starve == c_STARVE_MAX);
    assign w_timeout  = c_TMO_EN && (r_wait == c_TMO_LAST);
    // A fetch is stale when the CPU has moved pc (branch/flush) while the
    // access was in flight; its data must not be reported.
    assign w_pc_match = (pc == r_mAddr);

`ifdef INST_BUF_EN
    // ------------------------------------------------------------------------
    // One-entry fetch buffer
    // ------------------------------------------------------------------------
    logic              r_buf_valid;
    logic [AW-1:0]     r_buf_tag;
    logic [DW-1:0]     r_buf_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_word  <= '0;
        end else if ((r_state == S_BUSY_I) && mAck && w_pc_match) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_mAddr;
            r_buf_word  <= mRData;
        end else if ((r_state == S_BUSY_D) && mAck && r_mWe &&
                     (r_mAddr[AW-1:2] == r_buf_tag[AW-1:2])) begin
            // Any store touching the buffered word (any byte lane) makes the
            // cached instruction untrustworthy.
            r_buf_valid <= 1'b0;
        end
    end

    assign w_buf_hit  = !w_data_req && r_buf_valid && (pc == r_buf_tag);
    assign w_buf_word = r_buf_word;
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_word = '0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration / transaction FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mReq        <= 1'b0;
            r_mWe         <= 1'b0;
            r_mAddr       <= '0;
            r_mWData      <= '0;
            r_mMode       <= '0;
            r_inst        <= '0;
            r_instReady   <= 1'b0;
            r_readMemData <= '0;
            r_dataReady   <= 1'b0;
            r_busErr      <= 1'b0;
            r_starve      <= '0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (w_data_req && !w_starved) begin
                        // Data grant; a simultaneous read+write is a write.
                        r_state  <= S_BUSY_D;
                        r_mReq   <= 1'b1;
                        r_mWe    <= memWrite;
                        r_mAddr  <= dataAddress;
                        r_mWData <= writeMemData;
                        r_mMode  <= memMode;
                        // Cannot overflow: this branch is blocked once saturated.
                        r_starve <= r_starve + c_SW'(1);
                    end else if (w_buf_hit) begin
                        // Buffered fetch: no memory access, starve count kept.
                        r_state     <= S_DONE;
                        r_inst      <= w_buf_word;
                        r_instReady <= 1'b1;
                    end else begin
                        // Fetch grant (fetch is always pending).
                        r_state  <= S_BUSY_I;
                        r_mReq   <= 1'b1;
                        r_mWe    <= 1'b0;
                        r_mAddr  <= pc;
                        r_mMode  <= WORD_MODE;
                        r_starve <= '0;
                    end
                end

                S_BUSY_I, S_BUSY_D: begin
                    if (mAck) begin
                        r_mReq  <= 1'b0;
                        r_state <= S_DONE;
                        if (r_state == S_BUSY_I) begin
                            if (w_pc_match) begin
                                r_inst      <= mRData;
                                r_instReady <= 1'b1;
                            end
                        end else begin
                            // Completes even if the requester has dropped
                            // memRead/memWrite meanwhile.
                            r_readMemData <= mRData;
                            r_dataReady   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Abandon the access; the requester simply retries.
                        r_mReq   <= 1'b0;
                        r_busErr <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end

                S_DONE: begin
                    r_instReady <= 1'b0;
                    r_dataReady <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign mReq        = r_mReq;
    assign mWe         = r_mWe;
    assign mAddr       = r_mAddr;
    assign mWData      = r_mWData;
    assign mMode       = r_mMode;
    assign inst        = r_inst;
    assign instReady   = r_instReady;
    assign readMemData = r_readMemData;
    assign dataReady   = r_dataReady;
    assign busErr      = r_busErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A memory responder
//               answers mReq after a programmable delay; a monitor pops
//               expected {port, data, cycle} entries from a scoreboard on
//               every ready pulse and logs each grant for sequence checks.
//               Runs with STARVE_MAX=4, TIMEOUT=8. Honours INST_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int         AW     = 32;
    localparam int         DW     = 32;
    localparam int         MMD_W  = 3;
    localparam logic [2:0] c_WORD = 3'd2;

    logic             clk          = 1'b0;
    logic             reset        = 1'b1;
    logic [AW-1:0]    pc           = '0;
    logic [DW-1:0]    inst;
    logic             instReady;
    logic [AW-1:0]    dataAddress  = '0;
    logic [DW-1:0]    writeMemData = '0;
    logic             memRead      = 1'b0;
    logic             memWrite     = 1'b0;
    logic [MMD_W-1:0] memMode      = '0;
    logic [DW-1:0]    readMemData;
    logic             dataReady;
    logic             mReq;
    logic             mWe;
    logic [AW-1:0]    mAddr;
    logic [DW-1:0]    mWData;
    logic [MMD_W-1:0] mMode;
    logic             mAck         = 1'b0;
    logic [DW-1:0]    mRData       = '0;
    logic             busErr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MMD_W(MMD_W),
        .STARVE_MAX(4), .TIMEOUT(8), .WORD_MODE(c_WORD)
    ) dut (
        .clk(clk), .reset(reset),
        .pc(pc), .inst(inst), .instReady(instReady),
        .dataAddress(dataAddress), .writeMemData(writeMemData),
        .memRead(memRead), .memWrite(memWrite), .memMode(memMode),
        .readMemData(readMemData), .dataReady(dataReady),
        .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData), .mMode(mMode),
        .mAck(mAck), .mRData(mRData), .busErr(busErr)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [32:0] grants[$];      // {mWe, mAddr} at each mReq rise
    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    bit          resp_on   = 1'b1;
    int          ack_delay = 0;
    int          busy_cnt  = 0;
    bit          mreq_q    = 1'b0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h2402000A ^ {a[27:0], 4'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cycle index since reset release: 0 in the first IDLE cycle
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // backing-memory responder
    initial begin
        forever begin
            @(negedge clk);
            if (resp_on) begin
                if (mReq && !reset) begin
                    mAck   = (busy_cnt == ack_delay);
                    mRData = mAck ? mem_val(mAddr) : 32'h0;
                    busy_cnt++;
                end else begin
                    mAck     = 1'b0;
                    mRData   = 32'h0;
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic sb_check(input bit is_d, input logic [31:0] val);
        exp_t e;
        n_cmp++;
        assert (sbq.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_ready observed=port%0d data=%0h cyc=%0d expected=none", is_d, val, cyc);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check(is_d ? "dataReady" : "instReady",
                  {15'd0, is_d, val, 16'(cyc)}, {15'd0, e.is_d, e.val, 16'(e.cyc)});
        end
    endtask

    // monitor: ready pulses and grant log
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mreq_q = 1'b0;
            end else begin
                if (mReq && !mreq_q) grants.push_back({mWe, mAddr});
                mreq_q = mReq;
                if (instReady) sb_check(1'b0, inst);
                if (dataReady) sb_check(1'b1, readMemData);
            end
        end
    end

    task automatic to_cyc(input int k);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != k && guard < 200);
        if (cyc != k) check("cyc_reach", 64'(cyc), 64'(k));
    endtask

    task automatic check_reset_state();
        check("rst_mReq",        64'(mReq),        64'd0);
        check("rst_mWe",         64'(mWe),         64'd0);
        check("rst_instReady",   64'(instReady),   64'd0);
        check("rst_dataReady",   64'(dataReady),   64'd0);
        check("rst_busErr",      64'(busErr),      64'd0);
        check("rst_inst",        64'(inst),        64'd0);
        check("rst_readMemData", 64'(readMemData), 64'd0);
        check("rst_mAddr",       64'(mAddr),       64'd0);
        check("rst_mWData",      64'(mWData),      64'd0);
        check("rst_mMode",       64'(mMode),       64'd0);
    endtask

    // Asserts reset, returns at negedge+1 with reset still high.
    task automatic begin_scn();
        @(negedge clk); #1;
        reset = 1'b1;
        sbq.delete();
        grants.delete();
        memRead   = 1'b0;
        memWrite  = 1'b0;
        mAck      = 1'b0;
        mRData    = '0;
        resp_on   = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        check_reset_state();
        #1;
    endtask

    task automatic end_scn();
        #1;
        check("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic [32:0] exp_g[7];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_reset_state();

        // ---------------- A: fetch only, 1-cycle memory ----------------
        begin_scn();
        pc = 32'h0;
        reset = 1'b0;
        sbq.push_back('{1'b0, 32'h2402000A, 2});
        to_cyc(1);
        check("A_mReq",  64'(mReq),  64'd1);
        check("A_mAddr", 64'(mAddr), 64'd0);
        check("A_mMode", 64'(mMode), 64'(c_WORD));
        check("A_mWe",   64'(mWe),   64'd0);
        to_cyc(2);
        check("A_inst",  64'(inst),  64'h2402000A);
        check("A_mWe2",  64'(mWe),   64'd0);
        check("A_mReq2", 64'(mReq),  64'd0);
        to_cyc(3);
        end_scn();

        // ---------------- B: data priority over fetch ----------------
        begin_scn();
        pc = 32'h8; dataAddress = 32'h100; memRead = 1'b1; memMode = 3'b101;
        reset = 1'b0;
        sbq.push_back('{1'b1, mem_val(32'h100), 2});
        sbq.push_back('{1'b0, mem_val(32'h8),   5});
        to_cyc(1);
        check("B_mAddr_d", 64'(mAddr), 64'h100);
        check("B_mMode_d", 64'(mMode), 64'd5);
        check("B_mWe_d",   64'(mWe),   64'd0);
        to_cyc(2);
        #1 memRead = 1'b0;
        to_cyc(4);
        check("B_mAddr_i", 64'(mAddr), 64'h8);
        check("B_mMode_i", 64'(mMode), 64'(c_WORD));
        to_cyc(6);
        end_scn();
        check("B_grants", 64'(grants.size()), 64'd2);

        // ---------------- C: starvation guard, read+write = write ----------------
        begin_scn();
        pc = 32'h4; dataAddress = 32'h200; writeMemData = 32'hDEADBEEF;
        memRead = 1'b1; memWrite = 1'b1; memMode = 3'b000;
        reset = 1'b0;
        sbq.push_back('{1'b1, mem_val(32'h200), 2});
        sbq.push_back('{1'b1, mem_val(32'h200), 5});
        sbq.push_back('{1'b1, mem_val(32'h200), 8});
        sbq.push_back('{1'b1, mem_val(32'h200), 11});
        sbq.push_back('{1'b0, mem_val(32'h4),   14});
        sbq.push_back('{1'b1, mem_val(32'h200), 17});
        sbq.push_back('{1'b1, mem_val(32'h200), 20});
        to_cyc(1);
        check("C_mWe",    64'(mWe),    64'd1);
        check("C_mWData", 64'(mWData), 64'hDEADBEEF);
        to_cyc(20);
        end_scn();
        exp_g = '{{1'b1, 32'h200}, {1'b1, 32'h200}, {1'b1, 32'h200}, {1'b1, 32'h200},
                  {1'b0, 32'h4},   {1'b1, 32'h200}, {1'b1, 32'h200}};
        check("C_grants", 64'(grants.size()), 64'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < grants.size())
                check($sformatf("C_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
        end

        // ---------------- D: stale fetch after pc change ----------------
        begin_scn();
        pc = 32'h8; ack_delay = 2;
        reset = 1'b0;
        sbq.push_back('{1'b0, mem_val(32'h40), 9});
        to_cyc(2);
        #1 pc = 32'h40;
        to_cyc(4);
        check("D_noReady", 64'(instReady), 64'd0);
        to_cyc(6);
        check("D_mReq",  64'(mReq),  64'd1);
        check("D_mAddr", 64'(mAddr), 64'h40);
        to_cyc(10);
        end_scn();
        check("D_grants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("D_grant0", 64'(grants[0]), 64'({1'b0, 32'h8}));
            check("D_grant1", 64'(grants[1]), 64'({1'b0, 32'h40}));
        end

        // ---------------- E: timeout, sticky busErr, async reset ----------------
        begin_scn();
        resp_on = 1'b0; pc = 32'h20;
        reset = 1'b0;
        hi = 0;
        for (int k = 1; k <= 8; k++) begin
            to_cyc(k);
            if (mReq) hi++;
        end
        check("E_busErr_pre", 64'(busErr), 64'd0);
        to_cyc(9);
        if (mReq) hi++;
        check("E_req_cycles", 64'(hi),     64'd8);
        check("E_busErr",     64'(busErr), 64'd1);
        to_cyc(10);
        check("E_mReq_idle",  64'(mReq),   64'd0);
        to_cyc(11);
        check("E_retry_mReq", 64'(mReq),   64'd1);
        check("E_sticky",     64'(busErr), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("E_async_mReq",   64'(mReq),   64'd0);
        check("E_async_busErr", 64'(busErr), 64'd0);
        end_scn();

        // mAck while IDLE is ignored
        @(negedge clk); #1;
        reset = 1'b0;
        mAck = 1'b1; mRData = 32'hBAD0BAD0;
        to_cyc(1);
        check("F_mReq1", 64'(mReq), 64'd1);
        #1 mAck = 1'b0; mRData = '0;
        to_cyc(2);
        check("F_mReq2",  64'(mReq),      64'd1);
        check("F_noRdy",  64'(instReady), 64'd0);
        check("F_busErr", 64'(busErr),    64'd0);
        end_scn();

        // ---------------- G: repeated fetch of the same pc ----------------
        begin_scn();
        pc = 32'h10;
        reset = 1'b0;
`ifdef INST_BUF_EN
        sbq.push_back('{1'b0, mem_val(32'h10), 2});
        sbq.push_back('{1'b0, mem_val(32'h10), 4});
        sbq.push_back('{1'b1, mem_val(32'h12), 7});
        sbq.push_back('{1'b0, mem_val(32'h10), 10});
        to_cyc(3);
        check("G_hit_noReq3", 64'(mReq), 64'd0);
        to_cyc(4);
        check("G_hit_noReq4", 64'(mReq), 64'd0);
        #1;
        memWrite = 1'b1; dataAddress = 32'h12; writeMemData = 32'h12345678; memMode = 3'b001;
        to_cyc(6);
        check("G_st_mReq",  64'(mReq),  64'd1);
        check("G_st_mAddr", 64'(mAddr), 64'h12);
        check("G_st_mWe",   64'(mWe),   64'd1);
        to_cyc(7);
        #1 memWrite = 1'b0;
        to_cyc(9);
        check("G_miss_mReq",  64'(mReq),  64'd1);
        check("G_miss_mAddr", 64'(mAddr), 64'h10);
        check("G_miss_mWe",   64'(mWe),   64'd0);
        to_cyc(10);
`else
        sbq.push_back('{1'b0, mem_val(32'h10), 2});
        sbq.push_back('{1'b0, mem_val(32'h10), 5});
        to_cyc(4);
        check("G_refetch_mReq",  64'(mReq),  64'd1);
        check("G_refetch_mAddr", 64'(mAddr), 64'h10);
        to_cyc(5);
`endif
        end_scn();

        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
